// File: rtl/divider_issue_unit.sv
// Front-end sequencer for the repeated-subtraction divider: buffers operand pairs,
// issues one Req per operation, intercepts divide-by-zero and aborts hung operations.
module divider_issue_unit #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 300
) (
    input  logic             Clock,
    input  logic             nReset,

    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InDividend,
    input  logic [WIDTH-1:0] InDivisor,

    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutQuotient,
    output logic [WIDTH-1:0] OutRemainder,
    output logic             OutDivZero,
    output logic             OutTimeout,

    output logic             Req,
    output logic [WIDTH-1:0] Dividend,
    output logic [WIDTH-1:0] Divisor,
    output logic             DivClear,
    input  logic             Done,
    input  logic [WIDTH-1:0] Quotient,
    input  logic [WIDTH-1:0] Remainder
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ZERO,
        ABORT,
        HOLD
    } state_t;

    state_t           state;

    logic [WIDTH-1:0] fifo_dividend [DEPTH];
    logic [WIDTH-1:0] fifo_divisor  [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head_dividend;
    logic [WIDTH-1:0] head_divisor;
    logic             push;
    logic             pop;

    logic [WW-1:0]    watchdog;
    logic             abort_phase;

    assign InReady       = (count < CW'(DEPTH));
    assign push          = InValid && InReady;
    // The head leaves the FIFO only at the IDLE->ISSUE / IDLE->ZERO decision.
    assign pop           = (state == IDLE) && (count != '0);
    assign head_dividend = fifo_dividend[rd_ptr];
    assign head_divisor  = fifo_divisor[rd_ptr];

    // NOTE: storage needs no reset; an entry is only read once count says it was written.
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_dividend[wr_ptr] <= InDividend;
            fifo_divisor[wr_ptr]  <= InDivisor;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state        <= IDLE;
            Req          <= 1'b0;
            Dividend     <= '0;
            Divisor      <= '0;
            DivClear     <= 1'b0;
            watchdog     <= '0;
            abort_phase  <= 1'b0;
            OutValid     <= 1'b0;
            OutQuotient  <= '0;
            OutRemainder <= '0;
            OutDivZero   <= 1'b0;
            OutTimeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        Dividend <= head_dividend;
                        Divisor  <= head_divisor;
                        if (head_divisor == '0) begin
                            state <= ZERO;
                        end else begin
                            Req   <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    Req      <= 1'b0;
                    watchdog <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    // A Done arriving on the last watchdog cycle still counts as a normal finish.
                    if (Done) begin
                        OutQuotient  <= Quotient;
                        OutRemainder <= Remainder;
                        OutDivZero   <= 1'b0;
                        OutTimeout   <= 1'b0;
                        OutValid     <= 1'b1;
                        state        <= HOLD;
                    end else if (watchdog == WW'(TIMEOUT - 1)) begin
                        DivClear    <= 1'b1;
                        abort_phase <= 1'b0;
                        state       <= ABORT;
                    end else begin
                        watchdog <= watchdog + WW'(1);
                    end
                end

                ZERO: begin
                    OutQuotient  <= '1;
                    OutRemainder <= Dividend;
                    OutDivZero   <= 1'b1;
                    OutTimeout   <= 1'b0;
                    OutValid     <= 1'b1;
                    state        <= HOLD;
                end

                ABORT: begin
                    // DivClear stays high across both ABORT cycles to flush the divider.
                    if (!abort_phase) begin
                        abort_phase <= 1'b1;
                    end else begin
                        abort_phase  <= 1'b0;
                        DivClear     <= 1'b0;
                        OutQuotient  <= '1;
                        OutRemainder <= '1;
                        OutDivZero   <= 1'b0;
                        OutTimeout   <= 1'b1;
                        OutValid     <= 1'b1;
                        state        <= HOLD;
                    end
                end

                HOLD: begin
                    if (OutReady) begin
                        OutValid   <= 1'b0;
                        OutDivZero <= 1'b0;
                        OutTimeout <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    Req      <= 1'b0;
                    DivClear <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_issue_unit.sv
// Bench for divider_issue_unit: acts as the divider, drives random operand traffic and
// compares every issued operand pair and every delivered result with a transaction-level model.
module tb_divider_issue_unit;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 300;

    logic             Clock = 1'b0;
    logic             nReset = 1'b0;
    logic             InValid = 1'b0;
    logic             InReady;
    logic [WIDTH-1:0] InDividend = '0;
    logic [WIDTH-1:0] InDivisor = '0;
    logic             OutValid;
    logic             OutReady = 1'b0;
    logic [WIDTH-1:0] OutQuotient;
    logic [WIDTH-1:0] OutRemainder;
    logic             OutDivZero;
    logic             OutTimeout;
    logic             Req;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             DivClear;
    logic             Done = 1'b0;
    logic [WIDTH-1:0] Quotient = '0;
    logic [WIDTH-1:0] Remainder = '0;

    divider_issue_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .nReset(nReset),
        .InValid(InValid), .InReady(InReady), .InDividend(InDividend), .InDivisor(InDivisor),
        .OutValid(OutValid), .OutReady(OutReady), .OutQuotient(OutQuotient),
        .OutRemainder(OutRemainder), .OutDivZero(OutDivZero), .OutTimeout(OutTimeout),
        .Req(Req), .Dividend(Dividend), .Divisor(Divisor), .DivClear(DivClear),
        .Done(Done), .Quotient(Quotient), .Remainder(Remainder)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    op_t  ops[$];
    int   n_cmp = 0, n_bad = 0;
    int   cycle = 0, n_acc = 0, n_req = 0, n_dc = 0, last_acc_cycle = 0;
    bit   in_flight = 0, cur_hang = 0, hang_next = 0, stray_en = 0, force_stray = 0;
    int   hang_pct = 0, delay_next = 0, div_cnt = 0, req_cycle = 0, done_cycle = 0, dc_run = 0;
    bit   prev_req = 0, prev_dc = 0, prev_ov = 0, hold_chk = 0;
    logic [17:0] snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    // Divider stand-in: Done is a one-cycle pulse carrying the true quotient/remainder.
    task automatic drive_divider();
        Done = 1'b0;
        if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == 0 && ops.size() > 0) begin
                Done       = 1'b1;
                Quotient   = ops[0].a / ops[0].b;
                Remainder  = ops[0].a % ops[0].b;
                done_cycle = cycle;
            end
        end else if (force_stray || (stray_en && !in_flight && $urandom_range(0, 7) == 0)) begin
            Done        = 1'b1;
            Quotient    = 8'($urandom);
            Remainder   = 8'($urandom);
            force_stray = 0;
        end
    endtask

    task automatic score_result();
        op_t         op;
        logic [17:0] want;
        if (ops.size() == 0) begin
            check("result_unexpected", 32'd1, 32'd0);
            return;
        end
        op = ops.pop_front();
        if (op.b == 0)     want = {8'hFF, op.a, 2'b10};
        else if (cur_hang) want = {8'hFF, 8'hFF, 2'b01};
        else               want = {op.a / op.b, op.a % op.b, 2'b00};
        check("result", 32'(snap), 32'(want));
    endtask

    task automatic monitor();
        if (Req) begin
            n_req++;
            check("req_single_cycle", 32'(prev_req), 32'd0);
            if (ops.size() == 0) begin
                check("req_unexpected", 32'd1, 32'd0);
            end else begin
                check("req_operands", 32'({Dividend, Divisor}), 32'(ops[0]));
                check("req_divisor_nonzero", 32'(ops[0].b != 0), 32'd1);
                in_flight  = 1;
                req_cycle  = cycle;
                cur_hang   = hang_next || ($urandom_range(0, 99) < hang_pct);
                div_cnt    = cur_hang ? 0 : ((delay_next > 0) ? delay_next : $urandom_range(1, 12)) + 1;
                hang_next  = 0;
                delay_next = 0;
            end
        end else if (in_flight && !OutValid && ops.size() > 0) begin
            check("operands_held", 32'({Dividend, Divisor}), 32'(ops[0]));
        end
        if (DivClear && !prev_dc) begin
            check("abort_expected", 32'(cur_hang && in_flight), 32'd1);
            check("abort_timing", 32'(cycle - req_cycle), 32'(TIMEOUT + 1));
            dc_run = 0;
        end
        if (DivClear) begin
            dc_run++;
            n_dc++;
        end
        if (!DivClear && prev_dc) check("divclear_len", 32'(dc_run), 32'd2);
        if (OutValid && !prev_ov && in_flight) begin
            if (cur_hang) check("abort_result_latency", 32'(cycle - req_cycle), 32'(TIMEOUT + 3));
            else          check("result_latency", 32'(cycle - done_cycle), 32'd1);
            in_flight = 0;
        end
        if (hold_chk)
            check("hold_stable", 32'({OutValid, OutQuotient, OutRemainder, OutDivZero, OutTimeout}),
                  32'({1'b1, snap}));
        prev_req = Req;
        prev_dc  = DivClear;
        prev_ov  = OutValid;
    endtask

    task automatic step();
        bit acc_in, acc_out;
        drive_divider();
        acc_in   = nReset && InValid && InReady;
        acc_out  = nReset && OutValid && OutReady;
        hold_chk = nReset && OutValid && !OutReady;
        snap     = {OutQuotient, OutRemainder, OutDivZero, OutTimeout};
        if (acc_out) score_result();
        if (acc_in) begin
            ops.push_back({InDividend, InDivisor});
            n_acc++;
            last_acc_cycle = cycle;
        end
        @(posedge Clock);
        #1;
        cycle++;
        if (nReset) monitor();
    endtask

    task automatic apply_reset(input int n);
        nReset = 1'b0;
        ops.delete();
        in_flight = 0; cur_hang = 0; hang_next = 0; div_cnt = 0; delay_next = 0;
        prev_req = 0; prev_dc = 0; prev_ov = 0;
        for (int i = 0; i < n; i++) step();
        check("reset_ctrl", 32'({InReady, OutValid, Req, DivClear, OutDivZero, OutTimeout}), 32'b100000);
        check("reset_data", 32'({Dividend, Divisor, OutQuotient, OutRemainder}), 32'd0);
        nReset = 1'b1;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        int start;
        start = n_acc;
        InValid = 1'b1; InDividend = a; InDivisor = b;
        for (int i = 0; i < 1000 && n_acc == start; i++) step();
        InValid = 1'b0;
        check("push_accepted", 32'(n_acc - start), 32'd1);
    endtask

    task automatic wait_outvalid(input int budget);
        for (int i = 0; i < budget && !OutValid; i++) step();
        check("outvalid_seen", 32'(OutValid), 32'd1);
    endtask

    task automatic accept_result();
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
    endtask

    task automatic drain(input int budget);
        InValid = 1'b0; OutReady = 1'b1;
        for (int i = 0; i < budget && ops.size() > 0; i++) step();
        OutReady = 1'b0;
        step();
        check("drained", 32'(ops.size()), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_time_limit: got simulation still running expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int base_req, base_acc, base_dc;

        // Reset with InValid asserted, then one ordinary division.
        InValid = 1'b1; InDividend = 8'd100; InDivisor = 8'd7;
        apply_reset(3);
        InValid = 1'b0;
        step();
        base_req = n_req;
        delay_next = 5;
        push_pair(8'd100, 8'd7);
        wait_outvalid(100);
        check("t1_result", 32'({OutQuotient, OutRemainder, OutDivZero, OutTimeout}), 32'({8'd14, 8'd2, 2'b00}));
        check("t1_one_req", 32'(n_req - base_req), 32'd1);
        accept_result();

        // Back-pressure: FIFO fills behind the in-flight op; a fourth pair waits for consumption.
        delay_next = 20;
        push_pair(8'd200, 8'd9);
        push_pair(8'd77, 8'd11);
        push_pair(8'd255, 8'd1);
        check("t2_full", 32'(InReady), 32'd0);
        base_acc = n_acc;
        InValid = 1'b1; InDividend = 8'd13; InDivisor = 8'd5;
        wait_outvalid(100);
        for (int i = 0; i < 5; i++) step();
        check("t2_held_off", 32'(n_acc - base_acc), 32'd0);
        accept_result();
        for (int i = 0; i < 50 && n_acc == base_acc; i++) step();
        InValid = 1'b0;
        check("t2_after_consume", 32'(ops.size()), 32'd3);
        drain(500);

        // Divide by zero: no Req, result one cycle after the pop.
        base_req = n_req;
        push_pair(8'd55, 8'd0);
        wait_outvalid(20);
        check("t3_latency", 32'(cycle - last_acc_cycle), 32'd3);
        check("t3_result", 32'({OutQuotient, OutRemainder, OutDivZero, OutTimeout}), 32'({8'hFF, 8'd55, 2'b10}));
        check("t3_no_req", 32'(n_req - base_req), 32'd0);
        accept_result();

        // Watchdog abort, then a normal operation.
        base_dc = n_dc;
        hang_next = 1;
        push_pair(8'd9, 8'd3);
        wait_outvalid(TIMEOUT + 50);
        check("t4_result", 32'({OutQuotient, OutRemainder, OutDivZero, OutTimeout}), 32'({8'hFF, 8'hFF, 2'b01}));
        check("t4_divclear_cycles", 32'(n_dc - base_dc), 32'd2);
        accept_result();
        push_pair(8'd8, 8'd2);
        wait_outvalid(100);
        check("t4_next", 32'({OutQuotient, OutRemainder, OutDivZero, OutTimeout}), 32'({8'd4, 8'd0, 2'b00}));
        accept_result();

        // Done on the final watchdog cycle wins; stray Done in IDLE is ignored.
        base_dc = n_dc;
        delay_next = TIMEOUT;
        push_pair(8'd40, 8'd6);
        wait_outvalid(TIMEOUT + 50);
        check("t5_coincide", 32'({OutQuotient, OutRemainder, OutDivZero, OutTimeout}), 32'({8'd6, 8'd4, 2'b00}));
        check("t5_no_divclear", 32'(n_dc - base_dc), 32'd0);
        accept_result();
        base_req = n_req;
        step();
        force_stray = 1;
        for (int i = 0; i < 5; i++) step();
        check("t5_stray_ignored", 32'({OutValid, Req}), 32'd0);
        check("t5_stray_no_req", 32'(n_req - base_req), 32'd0);
        push_pair(8'd21, 8'd4);
        wait_outvalid(100);
        accept_result();

        // Reset during WAIT with two buffered entries.
        hang_next = 1;
        push_pair(8'd90, 8'd9);
        push_pair(8'd91, 8'd7);
        push_pair(8'd92, 8'd5);
        for (int i = 0; i < 5; i++) step();
        check("t6_full_before_reset", 32'(InReady), 32'd0);
        apply_reset(2);
        base_req = n_req;
        for (int i = 0; i < 10; i++) step();
        check("t6_idle_after_reset", 32'({InReady, OutValid, Req}), 32'b100);
        check("t6_no_issue", 32'(n_req - base_req), 32'd0);

        // Random traffic against the model.
        stray_en = 1;
        hang_pct = 2;
        for (int i = 0; i < 3000; i++) begin
            InValid    = ($urandom_range(0, 99) < 50);
            InDividend = 8'($urandom);
            InDivisor  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            OutReady   = ($urandom_range(0, 99) < 60);
            step();
        end
        stray_en = 0;
        hang_pct = 0;
        drain(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
